reorder_buffer: RTL
===================

# reorder_buffer

8-entry circular reorder buffer that sits on the receiving end of the functional-unit result buses (adder, multiplier, branch unit). It allocates tags at dispatch and captures broadcast `{tag, value}` results out of order. It retires entries strictly in program order to the register file and raises a pipeline flush when a mispredicted branch reaches the head.

## Interface
- `DEPTH`, 8: entry count; must equal 2**`TAG_W`.
- `TAG_W`, 3: tag width, matches FU `broadcast_tag`/`rob_tag`.
- `DATA_W`, 32: result width.
- `REG_W`, 5: architectural register index width.

Ports:
- `clk` in 1: single clock; block samples on posedge.
- `reset` in 1: synchronous, active-low.
- `alloc_valid` in 1: dispatch requests an entry.
- `alloc_is_branch` in 1: new entry is a beq (no destination write).
- `alloc_dest` in `REG_W`: destination register.
- `alloc_tag` out `TAG_W`: tag given to the request (equals tail pointer).
- `rob_full` out 1; `rob_empty` out 1.
- `add_trigger` in 1, `add_tag` in `TAG_W`, `add_val` in `DATA_W`: adder bus.
- `mul_trigger` in 1, `mul_tag` in `TAG_W`, `mul_val` in `DATA_W`: multiplier bus.
- `br_update` in 1, `br_mispredict` in 1, `br_tag` in `TAG_W`: branch unit result.
- `commit_valid` out 1: register write this cycle.
- `commit_reg` out `REG_W`, `commit_val` out `DATA_W`: register write target and data.
- `flush` out 1: one-cycle flush pulse.
- `lookup_tag_a`/`lookup_tag_b` in `TAG_W`, `lookup_ready_a`/`_b` out 1, `lookup_val_a`/`_b` out `DATA_W`: present only with `ROB_SRC_LOOKUP_EN`.

## Operation
- Entry fields: `valid`, `done`, `is_branch`, `mispredict`, `dest`, `value`. Pointers are `head`, `tail` (`TAG_W` bits, wrap 7→0), plus `count` (0..8, `TAG_W`+1 bits).
- `rob_full` = (`count`==8); `rob_empty` = (`count`==0). Both derive from registered `count`, not from same-cycle commits.
- **Allocate:** `alloc_valid` && !`rob_full` && no flush this cycle. Writes the entry at `tail` with `valid`=1, `done`=0, and fields from the inputs; then `tail`++. A request made while full is dropped, and the dispatcher must hold it.
- **Writeback:** a trigger high with a tag addressing a `valid` && !`done` entry sets `done`=1 and `value`=val. A trigger to an invalid or already-done entry is ignored.
  - Adder and multiplier with different tags in the same cycle: both are accepted.
  - Same tag on both: adder wins.
- **Branch update:** `br_update` on a valid branch entry sets `done`=1 and `mispredict`=`br_mispredict`.
- **Commit:** at most one per cycle, evaluated on pre-edge state. The head entry must be `valid` && `done`.
  - Non-branch: `commit_valid`=1, `commit_reg`/`commit_val` = entry fields; invalidate the entry; `head`++.
  - Branch, not mispredicted: retires silently (`commit_valid`=0).
  - Branch, mispredicted: `flush`=1, every entry invalidated, `head`=`tail`=`count`=0.
- `count` updates as +alloc −commit. Alloc and commit together leave it unchanged.

## Timing
- All outputs are registered except `alloc_tag`, `rob_full`, `rob_empty` (combinational from registers) and the lookup outputs.
- Reset (`reset`==0 at posedge):
  - all entries invalid; pointers and `count` = 0;
  - `commit_valid`/`flush` = 0, `commit_reg` = 0, `commit_val` = 0.
  - Reset mid-operation discards all in-flight entries. Triggers arriving during reset are ignored.
- Minimum latency: writeback captured at edge N; the head commit appears at edge N+1. A result broadcast to the head cannot commit in the same edge.
- Commit throughput: 1 per cycle with consecutive done entries.
- Flush cycle: allocation and writebacks that cycle are discarded. `alloc_tag` reads 0 the following cycle.
- FUs drive on negedge, so bus inputs are stable at posedge. No extra synchronisation is required.

## Configuration
- `ROB_SRC_LOOKUP_EN` defined: two combinational source-operand lookup ports.
  - `lookup_ready_x` = entry `valid` && `done`; `lookup_val_x` = entry value.
  - Same-cycle writeback is forwarded: a matching trigger forces ready=1 with the bus value.
- `ROB_SRC_LOOKUP_EN` undefined: the ports do not exist and no lookup logic is built.

## Structure
- Package `rob_pkg`: `TAG_W`, `DATA_W`, `REG_W`, `DEPTH` constants; `rob_entry_t` packed struct; `rob_tag_t` typedef. The FUs import `rob_tag_t`.
- Sub-module `rob_lookup_port`: one read port with writeback forwarding, instantiated twice under the macro.

## Test plan
- Reset, then allocate dest 3, 4, 5 → tags 0, 1, 2; `count`=3, `rob_empty`=0; all outputs 0 before allocation.
- Out-of-order completion: mul writes tag 1 = 42, then add writes tag 0 = 7 → commits r3=7, then r4=42 on consecutive cycles, in that order.
- Fill 8 entries → `rob_full`=1; the 9th `alloc_valid` is dropped and `tail` stays unchanged. Commit one entry → next alloc gets tag 0 (wrap).
- Simultaneous add tag 2 = 5 and mul tag 3 = 6 in one cycle → both entries done, committed in order.
- Branch at tag 1 gets `br_mispredict`=1 while tags 2–4 are pending → after tag 0 commits, `flush` is high for exactly 1 cycle, `rob_empty`=1, the tag 2–4 results are never committed, and the next alloc gets tag 0.
- With `ROB_SRC_LOOKUP_EN`: lookup tag 2 while add broadcasts tag 2 = 9 → `lookup_ready`=1, `lookup_val`=9 in the same cycle.

Source files
------------

// File: rtl/rob_pkg.sv
// rob_pkg: shared widths, tag type and entry layout for the reorder buffer and the FUs that target it
package rob_pkg;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 2 ** TAG_W;
  localparam int CNT_W  = TAG_W + 1;
  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef struct packed {
    logic              valid;
    logic              done;
    logic              is_branch;
    logic              mispredict;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;
endpackage

// File: rtl/rob_lookup_port.sv
// rob_lookup_port: one source-operand read port (ROB_SRC_LOOKUP_EN); ports: tag, ent (all entries), adder/mul buses in; ready, val out
`ifdef ROB_SRC_LOOKUP_EN
module rob_lookup_port
  import rob_pkg::*;
(
  input  rob_tag_t                 tag,
  input  rob_entry_t [DEPTH-1:0]   ent,
  input  logic                     add_trigger,
  input  rob_tag_t                 add_tag,
  input  logic [DATA_W-1:0]        add_val,
  input  logic                     mul_trigger,
  input  rob_tag_t                 mul_tag,
  input  logic [DATA_W-1:0]        mul_val,
  output logic                     ready,
  output logic [DATA_W-1:0]        val
);
  logic add_hit, mul_hit;
  always_comb begin
    add_hit = add_trigger && add_tag == tag;
    mul_hit = mul_trigger && mul_tag == tag;
    ready   = add_hit || mul_hit || (ent[tag].valid && ent[tag].done);
    val     = add_hit ? add_val : mul_hit ? mul_val : ent[tag].value;
  end
endmodule
`endif

// File: rtl/reorder_buffer.sv
// reorder_buffer: 8-entry circular ROB; allocates tags, captures out-of-order FU results, retires in order, flushes on mispredicted branch at head.
//   in : clk, reset (sync, active-low), alloc_valid/alloc_is_branch/alloc_dest, add_*/mul_* result buses, br_update/br_mispredict/br_tag
//   out: alloc_tag, rob_full, rob_empty, commit_valid/commit_reg/commit_val, flush
//   ROB_SRC_LOOKUP_EN: adds lookup_tag_a/b in, lookup_ready_a/b and lookup_val_a/b out
module reorder_buffer
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic              alloc_is_branch,
  input  logic [REG_W-1:0]  alloc_dest,
  output rob_tag_t          alloc_tag,
  output logic              rob_full,
  output logic              rob_empty,
  input  logic              add_trigger,
  input  rob_tag_t          add_tag,
  input  logic [DATA_W-1:0] add_val,
  input  logic              mul_trigger,
  input  rob_tag_t          mul_tag,
  input  logic [DATA_W-1:0] mul_val,
  input  logic              br_update,
  input  logic              br_mispredict,
  input  rob_tag_t          br_tag,
`ifdef ROB_SRC_LOOKUP_EN
  input  rob_tag_t          lookup_tag_a,
  input  rob_tag_t          lookup_tag_b,
  output logic              lookup_ready_a,
  output logic              lookup_ready_b,
  output logic [DATA_W-1:0] lookup_val_a,
  output logic [DATA_W-1:0] lookup_val_b,
`endif
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_reg,
  output logic [DATA_W-1:0] commit_val,
  output logic              flush
);
  rob_entry_t [DEPTH-1:0] ent;
  rob_tag_t head, tail;
  logic [CNT_W-1:0] count;
  rob_entry_t hd;
  logic do_flush, do_commit, do_alloc, add_ok, mul_ok, br_ok;
  assign alloc_tag = tail;
  assign rob_full  = count == CNT_W'(DEPTH);
  assign rob_empty = count == '0;
  always_comb begin
    hd        = ent[head];
    do_flush  = hd.valid && hd.done && hd.is_branch && hd.mispredict;
    do_commit = hd.valid && hd.done && !do_flush;
    do_alloc  = alloc_valid && !rob_full && !do_flush;
    add_ok    = add_trigger && ent[add_tag].valid && !ent[add_tag].done;
    // adder owns a tag both buses target in the same cycle
    mul_ok    = mul_trigger && ent[mul_tag].valid && !ent[mul_tag].done && !(add_trigger && add_tag == mul_tag);
    br_ok     = br_update && ent[br_tag].valid && ent[br_tag].is_branch && !ent[br_tag].done;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      ent          <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_reg   <= '0;
      commit_val   <= '0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= do_commit && !hd.is_branch;
      flush        <= do_flush;
      if (do_commit && !hd.is_branch) begin
        commit_reg <= hd.dest;
        commit_val <= hd.value;
      end
      if (do_flush) begin
        ent   <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (br_ok) begin
          ent[br_tag].done       <= 1'b1;
          ent[br_tag].mispredict <= br_mispredict;
        end
        if (mul_ok) begin
          ent[mul_tag].done  <= 1'b1;
          ent[mul_tag].value <= mul_val;
        end
        if (add_ok) begin
          ent[add_tag].done  <= 1'b1;
          ent[add_tag].value <= add_val;
        end
        if (do_commit) begin
          ent[head].valid <= 1'b0;
          head            <= head + TAG_W'(1);
        end
        if (do_alloc) begin
          ent[tail] <= '{valid: 1'b1, done: 1'b0, is_branch: alloc_is_branch, mispredict: 1'b0, dest: alloc_dest, value: '0};
          tail      <= tail + TAG_W'(1);
        end
        count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
      end
    end
  end
`ifdef ROB_SRC_LOOKUP_EN
  rob_lookup_port u_lookup_a (
    .tag(lookup_tag_a), .ent(ent),
    .add_trigger(add_trigger), .add_tag(add_tag), .add_val(add_val),
    .mul_trigger(mul_trigger), .mul_tag(mul_tag), .mul_val(mul_val),
    .ready(lookup_ready_a), .val(lookup_val_a)
  );
  rob_lookup_port u_lookup_b (
    .tag(lookup_tag_b), .ent(ent),
    .add_trigger(add_trigger), .add_tag(add_tag), .add_val(add_val),
    .mul_trigger(mul_trigger), .mul_tag(mul_tag), .mul_val(mul_val),
    .ready(lookup_ready_b), .val(lookup_val_b)
  );
`endif
endmodule
